// File: rtl/ea_sequencer.sv
// ---------------------------------------------------------------------------
// ea_sequencer
//   Turns a decoded 6502 address mode into an effective address. It runs the
//   operand fetches at PC, fetches an optional 16-bit pointer, applies the
//   X/Y/SP index, and then presents EA and the operand byte count used for
//   the PC update.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, abort      begin a sequence / synchronously cancel one
//   mode[11:0]        one-hot {imm,zp,zpx,zpy,dsp,abs,absx,absy,ix,iy,zi,sriy}
//   pc, x_reg, y_reg, sp_reg
//                     operand address and index registers, sampled with start
//   mem_req/mem_addr  bus read request and address
//   mem_ack/mem_din   read completion and read data
//   busy              sequence in progress
//   ea_valid          one-cycle pulse qualifying ea/op_bytes/page_cross
//   ea                effective address, held between pulses
//   op_bytes          operand bytes consumed at PC
//   page_cross        indexed add carried into the high byte
//   mode_err          one-cycle pulse when start arrives with a bad mode
// ---------------------------------------------------------------------------
module ea_sequencer #(
   parameter logic [7:0] ZP_PAGE = 8'h00,
   parameter logic [7:0] SP_PAGE = 8'h01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [11:0] mode,
   input  logic [15:0] pc,
   input  logic [7:0]  x_reg,
   input  logic [7:0]  y_reg,
   input  logic [7:0]  sp_reg,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_din,
   output logic        busy,
   output logic        ea_valid,
   output logic [15:0] ea,
   output logic [1:0]  op_bytes,
   output logic        page_cross,
   output logic        mode_err
);

   typedef enum logic [2:0] {
      IDLE,
      OP_LO,
      OP_HI,
      PTR_LO,
      PTR_HI,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [11:0] mode_q;
   logic [15:0] pc_q;
   logic [7:0]  x_q, y_q, sp_q;
   logic [7:0]  b_q, h_q, lo_q, hi_q;
   logic [15:0] ea_q;
   logic        mode_err_q;

   logic is_imm, is_zp, is_zpx, is_zpy, is_dsp, is_abs;
   logic is_absx, is_absy, is_ix, is_iy, is_zi, is_sriy;
   logic two_byte, indirect, indexed16;
   logic mode_ok, accept;

   logic [7:0]  ptr_page, ptr_base, ptr_next;
   logic [7:0]  idx16, zp_x_sum, zp_y_sum, sp_sum;
   logic [15:0] base16;
   logic [8:0]  low_sum;
   logic [15:0] ea_calc;
   logic [1:0]  ob_calc;

   assign is_imm  = mode_q[11];
   assign is_zp   = mode_q[10];
   assign is_zpx  = mode_q[9];
   assign is_zpy  = mode_q[8];
   assign is_dsp  = mode_q[7];
   assign is_abs  = mode_q[6];
   assign is_absx = mode_q[5];
   assign is_absy = mode_q[4];
   assign is_ix   = mode_q[3];
   assign is_iy   = mode_q[2];
   assign is_zi   = mode_q[1];
   assign is_sriy = mode_q[0];

   assign two_byte  = is_abs | is_absx | is_absy;
   assign indirect  = is_ix | is_iy | is_zi | is_sriy;
   assign indexed16 = is_absx | is_absy | is_iy | is_sriy;

   // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
   assign mode_ok = (mode != 12'd0) && ((mode & (mode - 12'd1)) == 12'd0);
   // Abort outranks start, so a simultaneous pair never launches a sequence.
   assign accept  = (state == IDLE) && start && !abort;

   // Pointer location: (zp,x) pre-indexes with X, (d,sp),y with SP, and the
   // high pointer byte always wraps inside the same page.
   assign ptr_page = is_sriy ? SP_PAGE : ZP_PAGE;
   assign ptr_base = b_q + (is_ix ? x_q : (is_sriy ? sp_q : 8'h00));
   assign ptr_next = ptr_base + 8'd1;

   // Next-state logic: each fetch state waits for its ack, abort cancels
   // every in-flight fetch, and DONE always lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && mode_ok)
               state_nxt = is_imm_in() ? DONE : OP_LO;
         end
         OP_LO: begin
            if (abort)
               state_nxt = IDLE;
            else if (mem_ack)
               state_nxt = two_byte ? OP_HI : (indirect ? PTR_LO : DONE);
         end
         OP_HI: begin
            if (abort)
               state_nxt = IDLE;
            else if (mem_ack)
               state_nxt = DONE;
         end
         PTR_LO: begin
            if (abort)
               state_nxt = IDLE;
            else if (mem_ack)
               state_nxt = PTR_HI;
         end
         PTR_HI: begin
            if (abort)
               state_nxt = IDLE;
            else if (mem_ack)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The mode register is not loaded yet in IDLE, so the immediate shortcut
   // has to look at the live mode input.
   function automatic logic is_imm_in();
      return mode[11];
   endfunction

   // Bus address for the current fetch; zero whenever no fetch is active.
   always_comb begin
      mem_addr = 16'h0000;
      case (state)
         OP_LO:   mem_addr = pc_q;
         OP_HI:   mem_addr = pc_q + 16'd1;
         PTR_LO:  mem_addr = {ptr_page, ptr_base};
         PTR_HI:  mem_addr = {ptr_page, ptr_next};
         default: mem_addr = 16'h0000;
      endcase
   end

   // Effective address from the captured bytes. The 16-bit indexed modes
   // share one adder: base is {h,b} for absolute forms and {hi,lo} for the
   // pointer forms, and the index is X only for abs,x.
   always_comb begin
      idx16    = is_absx ? x_q : y_q;
      base16   = two_byte ? {h_q, b_q} : {hi_q, lo_q};
      low_sum  = {1'b0, base16[7:0]} + {1'b0, idx16};
      zp_x_sum = b_q + x_q;
      zp_y_sum = b_q + y_q;
      sp_sum   = b_q + sp_q;
      ea_calc  = {hi_q, lo_q};
      ob_calc  = 2'd1;
      if (is_imm) begin
         ea_calc = pc_q;
         ob_calc = 2'd0;
      end else if (is_zp) begin
         ea_calc = {ZP_PAGE, b_q};
      end else if (is_zpx) begin
         ea_calc = {ZP_PAGE, zp_x_sum};
      end else if (is_zpy) begin
         ea_calc = {ZP_PAGE, zp_y_sum};
      end else if (is_dsp) begin
         ea_calc = {SP_PAGE, sp_sum};
      end else if (is_abs) begin
         ea_calc = {h_q, b_q};
         ob_calc = 2'd2;
      end else if (indexed16) begin
         ea_calc = base16 + {8'h00, idx16};
         ob_calc = two_byte ? 2'd2 : 2'd1;
      end
   end

   assign mem_req    = (state == OP_LO) || (state == OP_HI) ||
                       (state == PTR_LO) || (state == PTR_HI);
   assign busy       = (state != IDLE);
   assign ea_valid   = (state == DONE);
   assign ea         = ea_valid ? ea_calc : ea_q;
   assign op_bytes   = ea_valid ? ob_calc : 2'd0;
   assign page_cross = ea_valid && indexed16 && low_sum[8];
   assign mode_err   = mode_err_q;

   // State register plus operand capture. Each fetched byte is taken on its
   // ack cycle unless an abort is cancelling that same fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode_q     <= 12'd0;
         pc_q       <= 16'h0000;
         x_q        <= 8'h00;
         y_q        <= 8'h00;
         sp_q       <= 8'h00;
         b_q        <= 8'h00;
         h_q        <= 8'h00;
         lo_q       <= 8'h00;
         hi_q       <= 8'h00;
         ea_q       <= 16'h0000;
         mode_err_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         mode_err_q <= accept && !mode_ok;
         if (accept) begin
            mode_q <= mode;
            pc_q   <= pc;
            x_q    <= x_reg;
            y_q    <= y_reg;
            sp_q   <= sp_reg;
         end
         if (mem_ack && !abort) begin
            case (state)
               OP_LO:   b_q  <= mem_din;
               OP_HI:   h_q  <= mem_din;
               PTR_LO:  lo_q <= mem_din;
               PTR_HI:  hi_q <= mem_din;
               default: ;
            endcase
         end
         if (state == DONE)
            ea_q <= ea_calc;
      end
   end

endmodule

// File: tb/tb_ea_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ea_sequencer
//   Directed bench for ea_sequencer. A memory responder serves reads with a
//   programmable ack delay and checks every read address against a queue of
//   expected addresses; a monitor pops expected results whenever ea_valid
//   pulses and checks ea, op_bytes, page_cross and the pulse cycle.
// ---------------------------------------------------------------------------
module tb_ea_sequencer;

   localparam logic [11:0] M_IMM  = 12'h800;
   localparam logic [11:0] M_ZP   = 12'h400;
   localparam logic [11:0] M_ZPX  = 12'h200;
   localparam logic [11:0] M_ZPY  = 12'h100;
   localparam logic [11:0] M_DSP  = 12'h080;
   localparam logic [11:0] M_ABS  = 12'h040;
   localparam logic [11:0] M_ABSX = 12'h020;
   localparam logic [11:0] M_ABSY = 12'h010;
   localparam logic [11:0] M_IX   = 12'h008;
   localparam logic [11:0] M_IY   = 12'h004;
   localparam logic [11:0] M_ZI   = 12'h002;
   localparam logic [11:0] M_SRIY = 12'h001;

   typedef struct {
      logic [15:0] ea;
      logic [1:0]  ob;
      logic        pcr;
      int          cyc;
   } exp_t;

   logic        clk, rst_n, start, abort;
   logic [11:0] mode;
   logic [15:0] pc;
   logic [7:0]  x_reg, y_reg, sp_reg;
   logic        mem_req, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        busy, ea_valid, page_cross, mode_err;
   logic [15:0] ea;
   logic [1:0]  op_bytes;

   logic [7:0]  mem [0:65535];
   exp_t        sb[$];
   logic [15:0] addr_q[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          ack_delay = 0;
   int          mr_cnt = 0;
   int          me_cnt = 0;

   ea_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .pc         (pc),
      .x_reg      (x_reg),
      .y_reg      (y_reg),
      .sp_reg     (sp_reg),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_din    (mem_din),
      .busy       (busy),
      .ea_valid   (ea_valid),
      .ea         (ea),
      .op_bytes   (op_bytes),
      .page_cross (page_cross),
      .mode_err   (mode_err)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch with both values.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Launches one sequence from a falling edge and, when a result is
   // expected, queues it with the cycle its ea_valid pulse must appear in.
   task automatic applyStimulus(input logic [11:0] m, input logic [15:0] p,
                                input logic [7:0] xv, input logic [7:0] yv,
                                input logic [7:0] sv, input bit push,
                                input logic [15:0] e, input logic [1:0] ob,
                                input logic pcr, input int lat);
      exp_t it;
      @(negedge clk);
      mode   = m;
      pc     = p;
      x_reg  = xv;
      y_reg  = yv;
      sp_reg = sv;
      start  = 1'b1;
      if (push) begin
         it.ea  = e;
         it.ob  = ob;
         it.pcr = pcr;
         it.cyc = cyc + lat;
         sb.push_back(it);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for the scoreboard to drain and busy to drop.
   task automatic waitIdle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy)
            ok = 1'b1;
      end
      checkOutput({name, " done"}, 32'(ok), 32'd1);
      checkOutput({name, " reads left"}, 32'(addr_q.size()), 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " ea_valid"}, 32'(ea_valid), 32'd0);
      checkOutput({tag, " ea"}, 32'(ea), 32'd0);
      checkOutput({tag, " op_bytes"}, 32'(op_bytes), 32'd0);
      checkOutput({tag, " page_cross"}, 32'(page_cross), 32'd0);
      checkOutput({tag, " mode_err"}, 32'(mode_err), 32'd0);
   endtask

   // Memory responder after each rising edge, scoreboard monitor on each
   // falling edge. A new request pops the next expected address; while it
   // waits for its ack the address must not move.
   initial begin
      logic        in_req;
      int          wcnt;
      logic [15:0] held;
      exp_t        it;
      in_req  = 1'b0;
      wcnt    = 0;
      held    = 16'h0000;
      mem_ack = 1'b0;
      mem_din = 8'h00;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!mem_req) begin
            mem_ack = 1'b0;
            in_req  = 1'b0;
         end else begin
            if (!in_req) begin
               in_req = 1'b1;
               wcnt   = 0;
               held   = mem_addr;
               if (addr_q.size() == 0)
                  checkOutput("unexpected read", 32'(mem_addr), 32'hFFFFFFFF);
               else
                  checkOutput("read addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end else begin
               wcnt++;
               checkOutput("addr stable", 32'(mem_addr), 32'(held));
            end
            if (wcnt >= ack_delay) begin
               mem_ack = 1'b1;
               mem_din = mem[mem_addr];
               in_req  = 1'b0;
            end else begin
               mem_ack = 1'b0;
            end
         end
         @(negedge clk);
         if (mem_req)
            mr_cnt++;
         if (mode_err)
            me_cnt++;
         if (ea_valid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected ea_valid", 32'(ea), 32'hFFFFFFFF);
            end else begin
               it = sb.pop_front();
               checkOutput("ea", 32'(ea), 32'(it.ea));
               checkOutput("op_bytes", 32'(op_bytes), 32'(it.ob));
               checkOutput("page_cross", 32'(page_cross), 32'(it.pcr));
               checkOutput("ea_valid cycle", 32'(cyc), 32'(it.cyc));
               checkOutput("busy at ea_valid", 32'(busy), 32'd1);
            end
         end
      end
   end

   // Safety net in case anything above stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence of modes, boundaries, errors and cancels.
   initial begin
      int mr0, me0;
      bit found;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      mode  = 12'd0;
      pc    = 16'h0000;
      x_reg = 8'h00;
      y_reg = 8'h00;
      sp_reg = 8'h00;
      for (int i = 0; i < 65536; i++)
         mem[i] = 8'h00;
      mem[16'h0200] = 8'hF0;
      mem[16'h0300] = 8'hFF;  mem[16'h0301] = 8'h12;
      mem[16'h0400] = 8'hFE;  mem[16'h00FF] = 8'h34;  mem[16'h0000] = 8'h12;
      mem[16'h0500] = 8'h05;  mem[16'h01F5] = 8'hFF;  mem[16'h01F6] = 8'h00;
      mem[16'hFFFF] = 8'h78;
      mem[16'h0600] = 8'h20;
      mem[16'h0700] = 8'hFF;  mem[16'h0701] = 8'hFF;
      mem[16'h0800] = 8'h10;  mem[16'h0010] = 8'hF0;  mem[16'h0011] = 8'h12;
      mem[16'h0900] = 8'hFF;
      mem[16'h0A00] = 8'h80;
      mem[16'h0B00] = 8'h42;
      mem[16'h0C00] = 8'h10;
      #1;
      checkResetOutputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // imm: result one cycle after start and no bus activity at all.
      mr0 = mr_cnt;
      applyStimulus(M_IMM, 16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 16'h1234, 2'd0, 1'b0, 1);
      waitIdle("imm");
      checkOutput("imm no mem_req", 32'(mr_cnt - mr0), 32'd0);

      // zp,x wrapping inside page zero, zero-wait ack.
      ack_delay = 0;
      addr_q = '{16'h0200};
      applyStimulus(M_ZPX, 16'h0200, 8'h20, 8'h00, 8'h00, 1'b1, 16'h0010, 2'd1, 1'b0, 2);
      waitIdle("zpx");

      // abs,y with page cross and 3 wait cycles per read; a start issued
      // mid-sequence must be ignored.
      ack_delay = 3;
      addr_q = '{16'h0300, 16'h0301};
      applyStimulus(M_ABSY, 16'h0300, 8'h00, 8'h01, 8'h00, 1'b1, 16'h1300, 2'd2, 1'b1, 9);
      mode  = M_IMM;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitIdle("absy");

      // (zp,x) with pointer high byte wrapping to 0000.
      ack_delay = 0;
      addr_q = '{16'h0400, 16'h00FF, 16'h0000};
      applyStimulus(M_IX, 16'h0400, 8'h01, 8'h00, 8'h00, 1'b1, 16'h1234, 2'd1, 1'b0, 4);
      waitIdle("ix");

      // (d,sp),y with page cross, one wait cycle per read.
      ack_delay = 1;
      addr_q = '{16'h0500, 16'h01F5, 16'h01F6};
      applyStimulus(M_SRIY, 16'h0500, 8'h00, 8'h02, 8'hF0, 1'b1, 16'h0101, 2'd1, 1'b1, 7);
      waitIdle("sriy");

      // abs at pc=FFFF: second operand fetch wraps to 0000.
      ack_delay = 0;
      addr_q = '{16'hFFFF, 16'h0000};
      applyStimulus(M_ABS, 16'hFFFF, 8'h00, 8'h00, 8'h00, 1'b1, 16'h1278, 2'd2, 1'b0, 3);
      waitIdle("abs pc wrap");

      addr_q = '{16'h0600};
      applyStimulus(M_DSP, 16'h0600, 8'h00, 8'h00, 8'hF0, 1'b1, 16'h0110, 2'd1, 1'b0, 2);
      waitIdle("dsp");

      // abs,x FFFF+1 wraps to 0000 and carries out of the low byte.
      addr_q = '{16'h0700, 16'h0701};
      applyStimulus(M_ABSX, 16'h0700, 8'h01, 8'h00, 8'h00, 1'b1, 16'h0000, 2'd2, 1'b1, 3);
      waitIdle("absx wrap");

      addr_q = '{16'h0800, 16'h0010, 16'h0011};
      applyStimulus(M_IY, 16'h0800, 8'h00, 8'h05, 8'h00, 1'b1, 16'h12F5, 2'd1, 1'b0, 4);
      waitIdle("iy");

      addr_q = '{16'h0900, 16'h00FF, 16'h0000};
      applyStimulus(M_ZI, 16'h0900, 8'h00, 8'h00, 8'h00, 1'b1, 16'h1234, 2'd1, 1'b0, 4);
      waitIdle("zi");

      addr_q = '{16'h0A00};
      applyStimulus(M_ZPY, 16'h0A00, 8'h00, 8'h90, 8'h00, 1'b1, 16'h0010, 2'd1, 1'b0, 2);
      waitIdle("zpy");

      addr_q = '{16'h0B00};
      applyStimulus(M_ZP, 16'h0B00, 8'h00, 8'h00, 8'h00, 1'b1, 16'h0042, 2'd1, 1'b0, 2);
      waitIdle("zp");

      // Invalid modes: zero bits and two bits set.
      mr0 = mr_cnt;
      me0 = me_cnt;
      applyStimulus(12'h000, 16'h0B00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 2'd0, 1'b0, 0);
      checkOutput("mode_err zero", 32'(mode_err), 32'd1);
      checkOutput("mode_err busy", 32'(busy), 32'd0);
      applyStimulus(M_ZP | M_ABS, 16'h0B00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 2'd0, 1'b0, 0);
      checkOutput("mode_err two", 32'(mode_err), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("mode_err pulses", 32'(me_cnt - me0), 32'd2);
      checkOutput("mode_err no read", 32'(mr_cnt - mr0), 32'd0);

      // start and abort together in IDLE: abort wins.
      mr0 = mr_cnt;
      abort = 1'b1;
      applyStimulus(M_ZP, 16'h0B00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 2'd0, 1'b0, 0);
      checkOutput("start+abort busy", 32'(busy), 32'd0);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("start+abort no read", 32'(mr_cnt - mr0), 32'd0);

      // Abort while waiting in the pointer-high fetch: no result, ea holds.
      ack_delay = 3;
      addr_q = '{16'h0C00, 16'h0010, 16'h0011};
      applyStimulus(M_IY, 16'h0C00, 8'h00, 8'h05, 8'h00, 1'b0, 16'h0, 2'd0, 1'b0, 0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 16'h0011)
            found = 1'b1;
      end
      checkOutput("abort reached ptr_hi", 32'(found), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort mem_req", 32'(mem_req), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("abort ea held", 32'(ea), 32'h0042);
      checkOutput("abort reads left", 32'(addr_q.size()), 32'd0);

      // Reset mid-sequence: outputs clear without waiting for a clock edge.
      addr_q = '{16'h0D00, 16'h0D01};
      applyStimulus(M_ABS, 16'h0D00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 2'd0, 1'b0, 0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 16'h0D01)
            found = 1'b1;
      end
      checkOutput("reset reached op_hi", 32'(found), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("mid reset");
      @(negedge clk);
      rst_n = 1'b1;
      ack_delay = 0;
      repeat (4) @(negedge clk);
      checkOutput("reset no result", 32'(sb.size()), 32'd0);
      checkOutput("reset reads left", 32'(addr_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
